// File: rtl/inst_prefetch_queue.sv
// ---------------------------------------------------------------------------
// inst_prefetch_queue
//
// Instruction-fetch front end sitting between the program counter and the
// IF/ID pipeline register. It issues sequential word fetches to an
// instruction memory with variable latency (one request outstanding at most),
// buffers the returned words together with their PCs in a small FIFO, and
// presents the head entry to IF/ID. A redirect from ID (taken branch/jump)
// flushes the FIFO and restarts fetching at the new address.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   mem_req      registered fetch request to instruction memory
//   mem_addr     registered, word-aligned fetch byte address
//   mem_ready    memory accepts the request and returns data this cycle
//   mem_rdata    instruction word, valid when mem_req && mem_ready
//   redirect     flush the queue and restart fetch at redirect_pc
//   redirect_pc  new fetch address (bits [1:0] are forced to zero)
//   deq          IF/ID consumes the head entry (low = stall)
//   out_valid    head entry valid
//   out_instru   head instruction (zero when empty)
//   out_pc       PC of the head instruction (zero when empty)
//   count        number of occupied entries
// ---------------------------------------------------------------------------
module inst_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_W    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ready,
  input  logic [31:0]      mem_rdata,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic             deq,
  output logic             out_valid,
  output logic [31:0]      out_instru,
  output logic [31:0]      out_pc,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   CNT_ZERO  = (PTR_W + 1)'(32'd0);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(32'd1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(32'd0);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(32'd1);

  // Registered state
  logic [31:0]      instr_q_r [DEPTH];
  logic [31:0]      pc_q_r    [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W:0]   count_r;
  logic [31:0]      fetch_pc_r;
  logic             req_r;
  logic [31:0]      addr_r;
  logic             discard_r;

  // Next-state values
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [PTR_W-1:0] wr_ptr_nxt_s;
  logic [PTR_W:0]   count_nxt_s;
  logic [31:0]      fetch_pc_nxt_s;
  logic             req_nxt_s;
  logic [31:0]      addr_nxt_s;
  logic             discard_nxt_s;

  // Per-cycle events
  logic             done_s;
  logic             empty_s;
  logic             enq_s;
  logic             deq_s;

  // The two low redirect bits are intentionally dropped.
  logic             unused_pc_bits_s;
  assign unused_pc_bits_s = ^redirect_pc[1:0];

  // Next-state computation: queue bookkeeping, fetch address and request issue
  always_comb begin
    done_s  = req_r & mem_ready;
    empty_s = (count_r == CNT_ZERO);
    // A redirect drops any completing response and ignores any dequeue.
    enq_s   = done_s & ~discard_r & ~redirect;
    deq_s   = deq & ~empty_s & ~redirect;

    count_nxt_s    = count_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    wr_ptr_nxt_s   = wr_ptr_r;
    fetch_pc_nxt_s = fetch_pc_r;
    discard_nxt_s  = discard_r;
    req_nxt_s      = 1'b0;
    addr_nxt_s     = addr_r;

    if (redirect) begin
      count_nxt_s    = CNT_ZERO;
      rd_ptr_nxt_s   = PTR_ZERO;
      wr_ptr_nxt_s   = PTR_ZERO;
      fetch_pc_nxt_s = {redirect_pc[31:2], 2'b00};
      // A request still waiting for memory cannot be withdrawn; its data
      // must be thrown away when it finally arrives.
      discard_nxt_s  = req_r & ~mem_ready;
    end else begin
      case ({enq_s, deq_s})
        2'b10: begin
          count_nxt_s  = count_r + CNT_ONE;
          wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end
        2'b01: begin
          count_nxt_s  = count_r - CNT_ONE;
          rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end
        2'b11: begin
          wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
          rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end
        default: begin
          count_nxt_s = count_r;
        end
      endcase

      if (done_s) begin
        discard_nxt_s = 1'b0;
        // After a discarded response fetch_pc already holds the redirect
        // target and must not advance past it.
        if (discard_r) begin
          fetch_pc_nxt_s = fetch_pc_r;
        end else begin
          fetch_pc_nxt_s = addr_r + 32'd4;
        end
      end else begin
        discard_nxt_s = discard_r;
      end
    end

    // A waiting request holds its handshake; otherwise a new request is
    // issued only if the slot it will fill is free after this cycle.
    if (req_r && !mem_ready) begin
      req_nxt_s  = 1'b1;
      addr_nxt_s = addr_r;
    end else begin
      req_nxt_s  = (count_nxt_s < DEPTH_CNT);
      addr_nxt_s = fetch_pc_nxt_s;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r   <= PTR_ZERO;
      wr_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      fetch_pc_r <= RESET_PC;
      req_r      <= 1'b0;
      addr_r     <= RESET_PC;
      discard_r  <= 1'b0;
    end else begin
      rd_ptr_r   <= rd_ptr_nxt_s;
      wr_ptr_r   <= wr_ptr_nxt_s;
      count_r    <= count_nxt_s;
      fetch_pc_r <= fetch_pc_nxt_s;
      req_r      <= req_nxt_s;
      addr_r     <= addr_nxt_s;
      discard_r  <= discard_nxt_s;
    end
  end

  // FIFO storage; cleared on reset so no unknown value can ever leak out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_q_r[i] <= 32'h0000_0000;
        pc_q_r[i]    <= 32'h0000_0000;
      end
    end else begin
      if (enq_s) begin
        instr_q_r[wr_ptr_r] <= mem_rdata;
        pc_q_r[wr_ptr_r]    <= addr_r;
      end
    end
  end

  assign mem_req    = req_r;
  assign mem_addr   = addr_r;
  assign count      = count_r;
  assign out_valid  = ~empty_s;
  // Head is read combinationally but masked to zero while empty.
  assign out_instru = empty_s ? 32'h0000_0000 : instr_q_r[rd_ptr_r];
  assign out_pc     = empty_s ? 32'h0000_0000 : pc_q_r[rd_ptr_r];

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_prefetch_queue
//
// Self-checking bench for inst_prefetch_queue. The instruction memory model
// returns mem_addr ^ key as data. Expected PCs are pushed to a queue as the
// stimulus implies them and popped when the DUT presents a head entry that
// is being dequeued.
// ---------------------------------------------------------------------------
module tb_inst_prefetch_queue;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq;
  logic        out_valid;
  logic [31:0] out_instru;
  logic [31:0] out_pc;
  logic [2:0]  count;

  logic [31:0] key;
  logic [31:0] exp_q [$];
  logic [31:0] e;
  int          vectors;
  int          miscompares;

  inst_prefetch_queue #(
    .DEPTH    (4),
    .PTR_W    (2),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .deq         (deq),
    .out_valid   (out_valid),
    .out_instru  (out_instru),
    .out_pc      (out_pc),
    .count       (count)
  );

  assign mem_rdata = mem_addr ^ key;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0000_0000;
    deq         = 1'b0;
    mem_ready   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset;
    key = 32'h0000_0000;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0000_0000;
    deq = 1'b1; mem_ready = 1'b1;
    tick();
    vectors++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL reset_mem: got req %b addr %h expected 0 00000000", mem_req, mem_addr);
    end
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_count: got count %0d valid %b expected 0 0", count, out_valid);
    end
    vectors++;
    if (out_pc !== 32'h0000_0000 || out_instru !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL reset_head: got pc %h instr %h expected zeros", out_pc, out_instru);
    end
  endtask

  task automatic test_stream;
    key = 32'h0000_0000;
    do_reset();
    deq = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0000 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_first: got req %b addr %h valid %b expected 1 00000000 0",
               mem_req, mem_addr, out_valid);
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b1 || count > 3'd1) begin
        miscompares++;
        $display("FAIL stream_occ: got valid %b count %0d expected 1 and <=1", out_valid, count);
      end
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL stream_pc: got pc %h expected none", out_pc);
      end else begin
        e = exp_q.pop_front();
        if (out_pc !== e || out_instru !== (e ^ key)) begin
          miscompares++;
          $display("FAIL stream_pc: got pc %h instr %h expected %h %h", out_pc, out_instru, e, e ^ key);
        end
      end
    end
  endtask

  task automatic test_fill;
    int fetches;
    fetches = 0;
    key = 32'hA5A5_5A5A;
    do_reset();
    deq = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    for (int c = 0; c < 8; c++) begin
      tick();
      if (mem_req && mem_ready) fetches++;
    end
    vectors++;
    if (count !== 3'd4 || mem_req !== 1'b0 || fetches != 4) begin
      miscompares++;
      $display("FAIL fill_full: got count %0d req %b fetches %0d expected 4 0 4", count, mem_req, fetches);
    end
    deq = 1'b1;
    vectors++;
    e = exp_q.pop_front();
    if (out_pc !== e || out_instru !== (e ^ key)) begin
      miscompares++;
      $display("FAIL fill_head: got pc %h instr %h expected %h %h", out_pc, out_instru, e, e ^ key);
    end
    tick();
    deq = 1'b0;
    if (mem_req && mem_ready) fetches++;
    vectors++;
    if (count !== 3'd3 || mem_req !== 1'b1 || mem_addr !== 32'h0000_0010) begin
      miscompares++;
      $display("FAIL fill_refetch: got count %0d req %b addr %h expected 3 1 00000010",
               count, mem_req, mem_addr);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (mem_req && mem_ready) fetches++;
    end
    vectors++;
    if (count !== 3'd4 || mem_req !== 1'b0 || fetches != 5) begin
      miscompares++;
      $display("FAIL fill_refull: got count %0d req %b fetches %0d expected 4 0 5", count, mem_req, fetches);
    end
    mem_ready = 1'b0; deq = 1'b1;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL fill_drain: got pc %h expected none", out_pc);
      end else begin
        e = exp_q.pop_front();
        if (out_valid !== 1'b1 || out_pc !== e || out_instru !== (e ^ key)) begin
          miscompares++;
          $display("FAIL fill_drain: got valid %b pc %h instr %h expected 1 %h %h",
                   out_valid, out_pc, out_instru, e, e ^ key);
        end
      end
      tick();
    end
    tick();
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0000_0000 || out_instru !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL fill_empty: got count %0d valid %b pc %h instr %h expected 0 0 zeros",
               count, out_valid, out_pc, out_instru);
    end
  endtask

  task automatic test_slow;
    int   popped;
    logic prev_req;
    logic prev_ready;
    logic [31:0] prev_addr;
    popped = 0; prev_req = 1'b0; prev_ready = 1'b0; prev_addr = 32'h0000_0000;
    key = 32'h1111_0000;
    do_reset();
    deq = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (prev_req && !prev_ready) begin
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin
          miscompares++;
          $display("FAIL slow_hold: got req %b addr %h expected 1 %h", mem_req, mem_addr, prev_addr);
        end
      end
      if (out_valid) begin
        popped++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL slow_order: got pc %h expected none", out_pc);
        end else begin
          e = exp_q.pop_front();
          if (out_pc !== e || out_instru !== (e ^ key)) begin
            miscompares++;
            $display("FAIL slow_order: got pc %h instr %h expected %h %h", out_pc, out_instru, e, e ^ key);
          end
        end
      end
      prev_req   = mem_req;
      prev_addr  = mem_addr;
      mem_ready  = ((i % 3) == 2);
      prev_ready = mem_ready;
    end
    vectors++;
    if (popped != 4) begin
      miscompares++;
      $display("FAIL slow_count: got %0d entries expected 4", popped);
    end
  endtask

  task automatic test_redirect_idle;
    key = 32'h0F0F_0000;
    do_reset();
    deq = 1'b0; mem_ready = 1'b1;
    repeat (4) tick();
    vectors++;
    if (count !== 3'd3) begin
      miscompares++;
      $display("FAIL redir_pre: got count %0d expected 3", count);
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0043; deq = 1'b1;
    tick();
    redirect = 1'b0;
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0000_0040) begin
      miscompares++;
      $display("FAIL redir_flush: got count %0d valid %b req %b addr %h expected 0 0 1 00000040",
               count, out_valid, mem_req, mem_addr);
    end
    exp_q.push_back(32'h0000_0040);
    exp_q.push_back(32'h0000_0044);
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      e = exp_q.pop_front();
      if (out_valid !== 1'b1 || out_pc !== e || out_instru !== (e ^ key)) begin
        miscompares++;
        $display("FAIL redir_head: got valid %b pc %h instr %h expected 1 %h %h",
                 out_valid, out_pc, out_instru, e, e ^ key);
      end
    end
  endtask

  task automatic test_redirect_pending(input bit twice);
    logic [31:0] target;
    target = twice ? 32'h0000_00C0 : 32'h0000_0080;
    key = 32'h00FF_0000;
    do_reset();
    deq = 1'b0; mem_ready = 1'b1;
    repeat (3) tick();
    vectors++;
    if (mem_addr !== 32'h0000_0008 || count !== 3'd2) begin
      miscompares++;
      $display("FAIL pend_pre: got addr %h count %0d expected 00000008 2", mem_addr, count);
    end
    mem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0080;
    tick();
    redirect = 1'b0;
    vectors++;
    if (count !== 3'd0 || mem_req !== 1'b1 || mem_addr !== 32'h0000_0008) begin
      miscompares++;
      $display("FAIL pend_hold: got count %0d req %b addr %h expected 0 1 00000008", count, mem_req, mem_addr);
    end
    if (twice) begin
      redirect = 1'b1; redirect_pc = 32'h0000_00C0;
    end
    tick();
    redirect = 1'b0;
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0008) begin
      miscompares++;
      $display("FAIL pend_hold2: got req %b addr %h expected 1 00000008", mem_req, mem_addr);
    end
    mem_ready = 1'b1;
    tick();
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== target) begin
      miscompares++;
      $display("FAIL pend_drop: got count %0d valid %b req %b addr %h expected 0 0 1 %h",
               count, out_valid, mem_req, mem_addr, target);
    end
    exp_q.push_back(target);
    exp_q.push_back(target + 32'd4);
    deq = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      e = exp_q.pop_front();
      if (out_valid !== 1'b1 || out_pc !== e || out_instru !== (e ^ key)) begin
        miscompares++;
        $display("FAIL pend_head: got valid %b pc %h instr %h expected 1 %h %h",
                 out_valid, out_pc, out_instru, e, e ^ key);
      end
    end
  endtask

  task automatic test_pc_wrap;
    key = 32'h3C3C_0000;
    do_reset();
    deq = 1'b1; mem_ready = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    vectors++;
    if (count !== 3'd0 || mem_addr !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_redir: got count %0d addr %h expected 0 fffffffc", count, mem_addr);
    end
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    tick();
    vectors++;
    if (mem_addr !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL wrap_addr: got addr %h expected 00000000", mem_addr);
    end
    for (int c = 0; c < 2; c++) begin
      vectors++;
      e = exp_q.pop_front();
      if (out_valid !== 1'b1 || out_pc !== e || out_instru !== (e ^ key)) begin
        miscompares++;
        $display("FAIL wrap_head: got valid %b pc %h instr %h expected 1 %h %h",
                 out_valid, out_pc, out_instru, e, e ^ key);
      end
      tick();
    end
  endtask

  task automatic test_async_reset;
    key = 32'h0000_0000;
    do_reset();
    deq = 1'b0; mem_ready = 1'b1;
    repeat (3) tick();
    mem_ready = 1'b0;
    tick();
    vectors++;
    if (count !== 3'd2 || mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_pre: got count %0d req %b expected 2 1", count, mem_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || count !== 3'd0 || out_valid !== 1'b0 || mem_addr !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL arst_clear: got req %b count %0d valid %b addr %h expected 0 0 0 00000000",
               mem_req, count, out_valid, mem_addr);
    end
    #2;
    rst_n = 1'b1;
    deq = 1'b1;
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0000 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL arst_restart: got req %b addr %h count %0d expected 1 00000000 0",
               mem_req, mem_addr, count);
    end
    mem_ready = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0000_0000 || count !== 3'd1) begin
      miscompares++;
      $display("FAIL arst_head: got valid %b pc %h count %0d expected 1 00000000 1", out_valid, out_pc, count);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    key         = 32'h0000_0000;
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0000_0000;
    deq         = 1'b0;
    mem_ready   = 1'b0;
    test_reset();
    test_stream();
    test_fill();
    test_slow();
    test_redirect_idle();
    test_redirect_pending(1'b0);
    test_redirect_pending(1'b1);
    test_pc_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
- Instruction-fetch front end between the program counter and the IF/ID pipeline register.
- Issues sequential word fetches to a variable-latency instruction memory port and buffers returned instructions with their PCs in a small FIFO.
- Presents the head entry to IF/ID.
- Flushes and refetches on a branch/jump redirect from ID, i.e. the c_if_flush path.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- PTR_W, 2, log2(DEPTH).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- mem_req  output  1  fetch request to instruction memory.
- mem_addr  output  32  fetch byte address, word aligned.
- mem_ready  input  1  memory accepts and returns data this cycle.
- mem_rdata  input  32  instruction word, valid when mem_req && mem_ready.
- redirect  input  1  flush and restart fetch (branch/jump taken in ID).
- redirect_pc  input  32  new fetch address; bits [1:0] ignored and forced to 0.
- deq  input  1  IF/ID consumes head entry (c_IFIDWrite); low means stall.
- out_valid  output  1  head entry valid.
- out_instru  output  32  head instruction.
- out_pc  output  32  PC of head instruction.
- count  output  PTR_W+1  occupied entries.

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC, rd_ptr=wr_ptr=0, count=0.
  - mem_req=0, discard=0, out_valid=0.
  - out_instru=0, out_pc=0.
  - Memory outputs are registered; mem_addr=RESET_PC during reset.
- Fetch, one outstanding request max:
  - mem_req asserts when count + pending_slot < DEPTH.
  - Once asserted, mem_req and mem_addr hold stable until mem_ready=1.
  - A transfer completes in the cycle with mem_req && mem_ready.
  - On completion: enqueue {mem_rdata, mem_addr} unless discard=1, and set fetch_pc=mem_addr+4 (wraps modulo 2^32).
  - mem_req may stay high back-to-back with mem_addr+4 if space remains after this cycle's enqueue and dequeue.
- Zero-latency memory (mem_ready tied 1): one instruction per cycle sustained; out_valid rises one cycle after the first mem_req.
- Dequeue:
  - deq && out_valid pops the head at the edge.
  - deq while empty is ignored; no pointer movement and no underflow.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Full (count=DEPTH):
  - No new mem_req issued.
  - A request already outstanding cannot exist, because the space check reserves a slot.
- Pointers wrap modulo DEPTH.
- out_valid=(count!=0); out_instru/out_pc reflect the head combinationally from storage.
- Redirect takes priority over deq and enqueue in the same cycle:
  - At the edge, the FIFO empties (count=0, rd_ptr=wr_ptr) and fetch_pc=redirect_pc.
  - Any deq that cycle is ignored.
  - If no request is outstanding, or the outstanding one completes in the redirect cycle: data is dropped, and next cycle mem_req=1 with mem_addr=redirect_pc.
  - If a request is outstanding and mem_ready=0: mem_req/mem_addr hold (handshake not broken) and discard=1.
  - The completing response is dropped and discard clears.
  - The next cycle issues redirect_pc.
  - A second redirect while discard=1 updates fetch_pc only; the newest redirect wins.
- Latency, ready tied 1: redirect in cycle N → mem_req with redirect_pc in N+1 → out_valid, out_pc=redirect_pc in N+2.
- Reset mid-transfer: all state clears immediately and mem_req drops. The memory must tolerate an abandoned request.
- No X propagation: storage contents are never read when count=0, and outputs are forced to 0 when empty.

Test Plan:
- Reset, mem_ready=1, memory returns addr as data, deq=1 always → out_pc=0,4,8,12… each cycle from cycle 2; out_instru==out_pc; count stays ≤1.
- deq=0 with ready=1 → four fetches (0,4,8,12), count=4, mem_req=0 thereafter. Then one deq → exactly one new fetch at 16; count returns to 4.
- mem_ready pulses every 3rd cycle → mem_addr stable while waiting; entries in order 0,4,8; no duplicates or gaps.
- redirect (redirect_pc=0x40) while count=3 and idle → next cycle count=0 and mem_req with addr 0x40; first valid out_pc=0x40.
- redirect to 0x80 while a request at 0x08 is pending with ready low 2 more cycles:
  - 0x08 data never enqueued; next request addr 0x80.
  - Repeat with a second redirect to 0xC0 before completion → first valid pc 0xC0.
- Assert rst_n=0 asynchronously mid-wait → mem_req=0, count=0, out_valid=0 before the next edge. Release → fetch restarts at RESET_PC.
